// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing the MiST IO SD sector channel between two requesters.
// Synchronises the SPI-domain ack/strobes, sequences the command and routes the byte stream.
module sd_sector_arbiter #(
  parameter int unsigned SECTOR_BYTES   = 512,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] req0_lba,
  input  logic        req0_rd,
  input  logic        req0_wr,
  output logic        req0_busy,
  output logic        req0_done,
  output logic        req0_err,
  output logic [7:0]  req0_rdata,
  output logic        req0_rvalid,
  input  logic [7:0]  req0_wdata,
  output logic        req0_wready,
  input  logic [31:0] req1_lba,
  input  logic        req1_rd,
  input  logic        req1_wr,
  output logic        req1_busy,
  output logic        req1_done,
  output logic        req1_err,
  output logic [7:0]  req1_rdata,
  output logic        req1_rvalid,
  input  logic [7:0]  req1_wdata,
  output logic        req1_wready,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_dout,
  input  logic        sd_dout_strobe,
  output logic [7:0]  sd_din,
  input  logic        sd_din_strobe
);

  localparam int unsigned CntW = $clog2(SECTOR_BYTES) + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StXfer} state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              rr_q, rr_d;
  logic              op_wr_q, op_wr_d;
  logic [31:0]       lba_q, lba_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [7:0]        din_q, din_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        wready_q, wready_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  // [0],[1] form the synchroniser; [2] holds the previous synchronised value for edge detect
  logic [2:0]        ack_sync_q, dout_sync_q, din_sync_q;

  logic       ack_rise, ack_fall, dout_rise, din_rise, any_edge;
  logic [1:0] pend;
  logic       gnt_sel;
  logic       busy;

  assign ack_rise  = ack_sync_q[1] & ~ack_sync_q[2];
  assign ack_fall  = ~ack_sync_q[1] & ack_sync_q[2];
  assign dout_rise = dout_sync_q[1] & ~dout_sync_q[2];
  assign din_rise  = din_sync_q[1] & ~din_sync_q[2];
  assign any_edge  = ack_rise | ack_fall | dout_rise | din_rise;
  assign pend      = {req1_rd | req1_wr, req0_rd | req0_wr};

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    op_wr_d  = op_wr_q;
    lba_d    = lba_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    rdata_d  = rdata_q;
    din_d    = din_q;
    rvalid_d = '0;
    wready_d = '0;
    done_d   = '0;
    err_d    = '0;
    gnt_sel  = 1'b0;

    case (state_q)
      StIdle: begin
        // Skip the done cycle so a requester still holding its level is not re-granted at once
        if (pend != 2'b00 && done_q == 2'b00) begin
          gnt_sel = (pend == 2'b11) ? rr_q : pend[1];
          gnt_d   = gnt_sel;
          lba_d   = gnt_sel ? req1_lba : req0_lba;
          op_wr_d = gnt_sel ? ~req1_rd : ~req0_rd;
          tmo_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWaitAck;
      StWaitAck: begin
        if (ack_rise) begin
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (!op_wr_q && dout_rise && cnt_q < CntW'(SECTOR_BYTES)) begin
          rdata_d          = sd_dout;
          rvalid_d[gnt_q]  = 1'b1;
          cnt_d            = cnt_q + 1'b1;
        end
        if (op_wr_q && din_rise) begin
          if (cnt_q < CntW'(SECTOR_BYTES)) begin
            din_d           = gnt_q ? req1_wdata : req0_wdata;
            wready_d[gnt_q] = 1'b1;
            cnt_d           = cnt_q + 1'b1;
          end else begin
            din_d = 8'h00;
          end
        end
        if (ack_fall) begin
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = (cnt_q != CntW'(SECTOR_BYTES));
          rr_d          = ~gnt_q;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StWaitAck || state_q == StXfer) begin
      tmo_d = any_edge ? '0 : tmo_q + 1'b1;
      if (!any_edge && tmo_q == TmoW'(TIMEOUT_CYCLES - 1) && state_d != StIdle) begin
        done_d[gnt_q] = 1'b1;
        err_d[gnt_q]  = 1'b1;
        rr_d          = ~gnt_q;
        state_d       = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      gnt_q       <= 1'b0;
      rr_q        <= 1'b0;
      op_wr_q     <= 1'b0;
      lba_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      rdata_q     <= '0;
      din_q       <= '0;
      rvalid_q    <= '0;
      wready_q    <= '0;
      done_q      <= '0;
      err_q       <= '0;
      ack_sync_q  <= '0;
      dout_sync_q <= '0;
      din_sync_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      op_wr_q     <= op_wr_d;
      lba_q       <= lba_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      rdata_q     <= rdata_d;
      din_q       <= din_d;
      rvalid_q    <= rvalid_d;
      wready_q    <= wready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ack_sync_q  <= {ack_sync_q[1:0], sd_ack};
      dout_sync_q <= {dout_sync_q[1:0], sd_dout_strobe};
      din_sync_q  <= {din_sync_q[1:0], sd_din_strobe};
    end
  end

  assign busy        = (state_q != StIdle);
  assign req0_busy   = busy & ~gnt_q;
  assign req1_busy   = busy & gnt_q;
  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];
  assign req0_err    = err_q[0];
  assign req1_err    = err_q[1];
  assign req0_rvalid = rvalid_q[0];
  assign req1_rvalid = rvalid_q[1];
  assign req0_wready = wready_q[0];
  assign req1_wready = wready_q[1];
  assign req0_rdata  = rdata_q;
  assign req1_rdata  = rdata_q;
  assign sd_lba      = lba_q;
  assign sd_rd       = (state_q == StIssue || state_q == StWaitAck) & ~op_wr_q;
  assign sd_wr       = (state_q == StIssue || state_q == StWaitAck) & op_wr_q;
  assign sd_din      = din_q;

endmodule
